// File: rtl/uart_cmd_responder.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | uart_cmd_responder : pops 'W' A D / 'R' A byte commands from the RX FIFO,   |
// | runs one 8-bit register-bus access and pushes one response byte to TX.      |
// | Revision 1.0                                                                |
// +-----------------------------------------------------------------------------+
module uart_cmd_responder #(
   parameter int TIMEOUT_CYCLES = 1000000,
   parameter int RD_LATENCY     = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_ready,
   input  logic [7:0] rx_byte,
   output logic       rx_read,
   input  logic       tx_fifo_full,
   output logic [7:0] tx_data,
   output logic       tx_start,
   output logic [7:0] bus_addr,
   output logic [7:0] bus_wdata,
   output logic       bus_we,
   output logic       bus_re,
   input  logic [7:0] bus_rdata,
   output logic       busy,
   output logic       err
);

   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam int RL_W = $clog2(RD_LATENCY + 1);

   localparam logic [7:0]      c_cmd_w   = 8'h57;
   localparam logic [7:0]      c_cmd_r   = 8'h52;
   localparam logic [7:0]      c_ack     = 8'h06;
   localparam logic [7:0]      c_nak     = 8'h15;
   localparam logic [TO_W-1:0] c_to_last = TO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [TO_W-1:0] c_to_one  = TO_W'(1);
   localparam logic [RL_W-1:0] c_rl      = RL_W'(RD_LATENCY);
   localparam logic [RL_W-1:0] c_rl_one  = RL_W'(1);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_GET_ADDR = 3'd1,
      S_GET_DATA = 3'd2,
      S_BUS_WR   = 3'd3,
      S_BUS_RD   = 3'd4,
      S_RD_WAIT  = 3'd5,
      S_SEND     = 3'd6,
      S_GAP      = 3'd7
   } state_t;

   state_t          state_q, state_d;
   logic            is_wr_q, is_wr_d;
   logic            armed_q, armed_d;
   logic [TO_W-1:0] to_cnt_q, to_cnt_d;
   logic [RL_W-1:0] rd_cnt_q, rd_cnt_d;
   logic            rx_read_q, rx_read_d;
   logic [7:0]      tx_data_q, tx_data_d;
   logic            tx_start_q, tx_start_d;
   logic [7:0]      bus_addr_q, bus_addr_d;
   logic [7:0]      bus_wdata_q, bus_wdata_d;
   logic            bus_we_q, bus_we_d;
   logic            bus_re_q, bus_re_d;
   logic            busy_q, busy_d;
   logic            err_q, err_d;
   logic            w_take;

   // The FIFO head is stale during the pop cycle, so never accept back to back.
   assign w_take = rx_ready && !rx_read_q;

   always_comb begin
      state_d     = state_q;
      is_wr_d     = is_wr_q;
      armed_d     = armed_q;
      to_cnt_d    = to_cnt_q;
      rd_cnt_d    = rd_cnt_q;
      tx_data_d   = tx_data_q;
      bus_addr_d  = bus_addr_q;
      bus_wdata_d = bus_wdata_q;
      rx_read_d   = 1'b0;
      tx_start_d  = 1'b0;
      bus_we_d    = 1'b0;
      bus_re_d    = 1'b0;
      err_d       = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (w_take) begin
               rx_read_d = 1'b1;
               to_cnt_d  = '0;
               if (rx_byte == c_cmd_w || rx_byte == c_cmd_r) begin
                  is_wr_d = (rx_byte == c_cmd_w);
                  state_d = S_GET_ADDR;
               end else begin
                  tx_data_d = c_nak;
                  err_d     = 1'b1;
                  armed_d   = 1'b0;
                  state_d   = S_SEND;
               end
            end
         end
         S_GET_ADDR, S_GET_DATA: begin
            if (w_take) begin
               rx_read_d = 1'b1;
               to_cnt_d  = '0;
               if (state_q == S_GET_ADDR) begin
                  bus_addr_d = rx_byte;
                  state_d    = is_wr_q ? S_GET_DATA : S_BUS_RD;
               end else begin
                  bus_wdata_d = rx_byte;
                  state_d     = S_BUS_WR;
               end
            end else if (!rx_ready) begin
               if (to_cnt_q == c_to_last) begin
                  err_d   = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  to_cnt_d = to_cnt_q + c_to_one;
               end
            end
         end
         S_BUS_WR: begin
            bus_we_d  = 1'b1;
            tx_data_d = c_ack;
            armed_d   = 1'b0;
            state_d   = S_SEND;
         end
         S_BUS_RD: begin
            bus_re_d = 1'b1;
            rd_cnt_d = '0;
            state_d  = S_RD_WAIT;
         end
         S_RD_WAIT: begin
            if (rd_cnt_q == c_rl) begin
               tx_data_d = bus_rdata;
               armed_d   = 1'b0;
               state_d   = S_SEND;
            end else begin
               rd_cnt_d = rd_cnt_q + c_rl_one;
            end
         end
         S_SEND: begin
            // One settle cycle with tx_data already held before the push edge.
            if (!armed_q) begin
               armed_d = 1'b1;
            end else if (!tx_fifo_full) begin
               tx_start_d = 1'b1;
               armed_d    = 1'b0;
               state_d    = S_GAP;
            end
         end
         S_GAP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         is_wr_q     <= 1'b0;
         armed_q     <= 1'b0;
         to_cnt_q    <= '0;
         rd_cnt_q    <= '0;
         rx_read_q   <= 1'b0;
         tx_data_q   <= 8'h00;
         tx_start_q  <= 1'b0;
         bus_addr_q  <= 8'h00;
         bus_wdata_q <= 8'h00;
         bus_we_q    <= 1'b0;
         bus_re_q    <= 1'b0;
         busy_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         is_wr_q     <= is_wr_d;
         armed_q     <= armed_d;
         to_cnt_q    <= to_cnt_d;
         rd_cnt_q    <= rd_cnt_d;
         rx_read_q   <= rx_read_d;
         tx_data_q   <= tx_data_d;
         tx_start_q  <= tx_start_d;
         bus_addr_q  <= bus_addr_d;
         bus_wdata_q <= bus_wdata_d;
         bus_we_q    <= bus_we_d;
         bus_re_q    <= bus_re_d;
         busy_q      <= busy_d;
         err_q       <= err_d;
      end
   end

   assign rx_read   = rx_read_q;
   assign tx_data   = tx_data_q;
   assign tx_start  = tx_start_q;
   assign bus_addr  = bus_addr_q;
   assign bus_wdata = bus_wdata_q;
   assign bus_we    = bus_we_q;
   assign bus_re    = bus_re_q;
   assign busy      = busy_q;
   assign err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_responder.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_uart_cmd_responder : directed bench, two instances (read latency 1 / 3). |
// | Revision 1.0                                                                |
// +-----------------------------------------------------------------------------+
module tb_uart_cmd_responder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       rx_ready[2];
   logic [7:0] rx_byte[2];
   logic       rx_read[2];
   logic       tx_fifo_full[2];
   logic [7:0] tx_data[2];
   logic       tx_start[2];
   logic [7:0] bus_addr[2];
   logic [7:0] bus_wdata[2];
   logic       bus_we[2];
   logic       bus_re[2];
   logic [7:0] bus_rdata[2];
   logic       busy[2];
   logic       err[2];

   uart_cmd_responder #(.TIMEOUT_CYCLES(16), .RD_LATENCY(1)) dut0 (
      .clk(clk), .rst(rst), .rx_ready(rx_ready[0]), .rx_byte(rx_byte[0]),
      .rx_read(rx_read[0]), .tx_fifo_full(tx_fifo_full[0]), .tx_data(tx_data[0]),
      .tx_start(tx_start[0]), .bus_addr(bus_addr[0]), .bus_wdata(bus_wdata[0]),
      .bus_we(bus_we[0]), .bus_re(bus_re[0]), .bus_rdata(bus_rdata[0]),
      .busy(busy[0]), .err(err[0])
   );

   uart_cmd_responder #(.TIMEOUT_CYCLES(40), .RD_LATENCY(3)) dut1 (
      .clk(clk), .rst(rst), .rx_ready(rx_ready[1]), .rx_byte(rx_byte[1]),
      .rx_read(rx_read[1]), .tx_fifo_full(tx_fifo_full[1]), .tx_data(tx_data[1]),
      .tx_start(tx_start[1]), .bus_addr(bus_addr[1]), .bus_wdata(bus_wdata[1]),
      .bus_we(bus_we[1]), .bus_re(bus_re[1]), .bus_rdata(bus_rdata[1]),
      .busy(busy[1]), .err(err[1])
   );

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   logic [7:0] q0[$];
   logic [7:0] q1[$];
   logic [7:0] txl0[$];
   logic [3:0] hist[2];

   int         rd_n[2], we_n[2], re_n[2], ts_n[2], err_n[2], rr_viol[2];
   int         last_rd_cyc[2], we_cyc[2], ts_cyc[2], err_cyc[2];
   logic       prev_rd[2];
   logic [7:0] we_addr[2], we_data[2], re_addr[2], last_tx[2];

   function automatic void refresh();
      rx_ready[0] = (q0.size() != 0);
      rx_byte[0]  = (q0.size() != 0) ? q0[0] : 8'h00;
      rx_ready[1] = (q1.size() != 0);
      rx_byte[1]  = (q1.size() != 0) ? q1[0] : 8'h00;
   endfunction

   function automatic void push(input int u, input logic [7:0] b);
      if (u == 0) q0.push_back(b);
      else        q1.push_back(b);
      refresh();
   endfunction

   always @(posedge clk) cyc++;

   // RX FIFO pops on the edge that ends an rx_read cycle; read data appears
   // exactly RD_LATENCY cycles after bus_re, garbage otherwise.
   always @(posedge clk) begin
      logic p0, p1;
      p0 = (rx_read[0] === 1'b1);
      p1 = (rx_read[1] === 1'b1);
      hist[0] = {hist[0][2:0], bus_re[0] === 1'b1};
      hist[1] = {hist[1][2:0], bus_re[1] === 1'b1};
      #1;
      if (p0 && q0.size() != 0) void'(q0.pop_front());
      if (p1 && q1.size() != 0) void'(q1.pop_front());
      refresh();
      bus_rdata[0] = hist[0][0] ? 8'h3C : 8'hEE;
      bus_rdata[1] = hist[1][2] ? 8'h3C : 8'hEE;
   end

   always @(negedge clk) begin
      for (int u = 0; u < 2; u++) begin
         if (rx_read[u] === 1'b1) begin
            rd_n[u]++;
            last_rd_cyc[u] = cyc;
            if (prev_rd[u]) rr_viol[u]++;
         end
         prev_rd[u] = (rx_read[u] === 1'b1);
         if (bus_we[u] === 1'b1) begin
            we_n[u]++; we_cyc[u] = cyc; we_addr[u] = bus_addr[u]; we_data[u] = bus_wdata[u];
         end
         if (bus_re[u] === 1'b1) begin
            re_n[u]++; re_addr[u] = bus_addr[u];
         end
         if (tx_start[u] === 1'b1) begin
            ts_n[u]++; ts_cyc[u] = cyc; last_tx[u] = tx_data[u];
            if (u == 0) txl0.push_back(tx_data[u]);
         end
         if (err[u] === 1'b1) begin
            err_n[u]++; err_cyc[u] = cyc;
         end
      end
   end

   task automatic clear_mon();
      @(posedge clk);
      #2;
      for (int u = 0; u < 2; u++) begin
         rd_n[u] = 0; we_n[u] = 0; re_n[u] = 0; ts_n[u] = 0; err_n[u] = 0; rr_viol[u] = 0;
         last_rd_cyc[u] = -1; we_cyc[u] = -1; ts_cyc[u] = -1; err_cyc[u] = -1;
         last_tx[u] = 8'hXX;
      end
      txl0.delete();
      @(negedge clk);
   endtask

   task automatic wait_done(input int u, input int maxc);
      int  n;
      bit  done;
      n = 0;
      done = 1'b0;
      while (!done && n < maxc) begin
         @(negedge clk);
         n++;
         done = ((u == 0) ? (q0.size() == 0) : (q1.size() == 0)) && busy[u] === 1'b0
                && rx_read[u] === 1'b0;
      end
      checks++;
      if (!done) begin
         failures++;
         $display("FAIL wait_done u%0d: still busy after %0d cycles, required idle", u, maxc);
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      for (int u = 0; u < 2; u++) begin
         checks++;
         if ({rx_read[u], tx_start[u], bus_we[u], bus_re[u], busy[u], err[u]} !== 6'b0) begin
            failures++;
            $display("FAIL reset_strobes u%0d: got %b, required 000000", u,
                     {rx_read[u], tx_start[u], bus_we[u], bus_re[u], busy[u], err[u]});
         end
         checks++;
         if ({tx_data[u], bus_addr[u], bus_wdata[u]} !== 24'h0) begin
            failures++;
            $display("FAIL reset_data u%0d: got %h, required 000000", u,
                     {tx_data[u], bus_addr[u], bus_wdata[u]});
         end
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_write();
      clear_mon();
      push(0, 8'h57); push(0, 8'h10); push(0, 8'hA5);
      wait_done(0, 60);
      checks++;
      if (we_n[0] !== 1 || we_addr[0] !== 8'h10 || we_data[0] !== 8'hA5) begin
         failures++;
         $display("FAIL write_bus: got n=%0d a=%h d=%h, required n=1 a=10 d=a5",
                  we_n[0], we_addr[0], we_data[0]);
      end
      checks++;
      if (ts_n[0] !== 1 || last_tx[0] !== 8'h06) begin
         failures++;
         $display("FAIL write_resp: got n=%0d tx=%h, required n=1 tx=06", ts_n[0], last_tx[0]);
      end
      checks++;
      if (we_cyc[0] - last_rd_cyc[0] !== 1 || ts_cyc[0] - last_rd_cyc[0] !== 3) begin
         failures++;
         $display("FAIL write_latency: got we=+%0d ts=+%0d, required we=+1 ts=+3",
                  we_cyc[0] - last_rd_cyc[0], ts_cyc[0] - last_rd_cyc[0]);
      end
      checks++;
      if (re_n[0] !== 0 || err_n[0] !== 0 || rr_viol[0] !== 0 || rd_n[0] !== 3) begin
         failures++;
         $display("FAIL write_side: got re=%0d err=%0d rr=%0d pops=%0d, required 0 0 0 3",
                  re_n[0], err_n[0], rr_viol[0], rd_n[0]);
      end
   endtask

   task automatic test_read(input int u);
      clear_mon();
      push(u, 8'h52); push(u, 8'h22);
      wait_done(u, 60);
      checks++;
      if (re_n[u] !== 1 || re_addr[u] !== 8'h22 || we_n[u] !== 0) begin
         failures++;
         $display("FAIL read_bus u%0d: got re=%0d a=%h we=%0d, required 1 22 0",
                  u, re_n[u], re_addr[u], we_n[u]);
      end
      checks++;
      if (ts_n[u] !== 1 || last_tx[u] !== 8'h3C) begin
         failures++;
         $display("FAIL read_resp u%0d: got n=%0d tx=%h, required n=1 tx=3c", u, ts_n[u], last_tx[u]);
      end
      checks++;
      if (bus_addr[u] !== 8'h22) begin
         failures++;
         $display("FAIL read_addr_hold u%0d: got %h, required 22", u, bus_addr[u]);
      end
   endtask

   task automatic test_nak();
      clear_mon();
      push(0, 8'h41);
      wait_done(0, 40);
      checks++;
      if (err_n[0] !== 1 || ts_n[0] !== 1 || last_tx[0] !== 8'h15 || we_n[0] + re_n[0] !== 0) begin
         failures++;
         $display("FAIL nak: got err=%0d ts=%0d tx=%h bus=%0d, required 1 1 15 0",
                  err_n[0], ts_n[0], last_tx[0], we_n[0] + re_n[0]);
      end
      push(0, 8'h52); push(0, 8'h01);
      wait_done(0, 60);
      checks++;
      if (re_n[0] !== 1 || re_addr[0] !== 8'h01 || ts_n[0] !== 2 || last_tx[0] !== 8'h3C
          || err_n[0] !== 1) begin
         failures++;
         $display("FAIL nak_recover: got re=%0d a=%h ts=%0d tx=%h err=%0d, required 1 01 2 3c 1",
                  re_n[0], re_addr[0], ts_n[0], last_tx[0], err_n[0]);
      end
   endtask

   task automatic test_timeout();
      clear_mon();
      push(0, 8'h57); push(0, 8'h10);
      wait_done(0, 80);
      checks++;
      if (err_n[0] !== 1 || err_cyc[0] - last_rd_cyc[0] !== 17) begin
         failures++;
         $display("FAIL timeout_err: got n=%0d at +%0d, required n=1 at +17",
                  err_n[0], err_cyc[0] - last_rd_cyc[0]);
      end
      checks++;
      if (ts_n[0] !== 0 || we_n[0] !== 0 || busy[0] !== 1'b0) begin
         failures++;
         $display("FAIL timeout_quiet: got ts=%0d we=%0d busy=%b, required 0 0 0",
                  ts_n[0], we_n[0], busy[0]);
      end
      clear_mon();
      push(0, 8'h57); push(0, 8'h10); push(0, 8'hA5);
      wait_done(0, 60);
      checks++;
      if (we_n[0] !== 1 || we_addr[0] !== 8'h10 || we_data[0] !== 8'hA5 || last_tx[0] !== 8'h06) begin
         failures++;
         $display("FAIL timeout_recover: got we=%0d a=%h d=%h tx=%h, required 1 10 a5 06",
                  we_n[0], we_addr[0], we_data[0], last_tx[0]);
      end
   endtask

   task automatic test_tx_full();
      clear_mon();
      tx_fifo_full[0] = 1'b1;
      push(0, 8'h57); push(0, 8'h44); push(0, 8'h5A);
      repeat (50) @(negedge clk);
      checks++;
      if (ts_n[0] !== 0 || we_n[0] !== 1 || busy[0] !== 1'b1) begin
         failures++;
         $display("FAIL full_hold: got ts=%0d we=%0d busy=%b, required 0 1 1", ts_n[0], we_n[0], busy[0]);
      end
      tx_fifo_full[0] = 1'b0;
      wait_done(0, 20);
      checks++;
      if (ts_n[0] !== 1 || last_tx[0] !== 8'h06) begin
         failures++;
         $display("FAIL full_release: got n=%0d tx=%h, required n=1 tx=06", ts_n[0], last_tx[0]);
      end
   endtask

   task automatic test_reset_mid();
      int n;
      clear_mon();
      push(0, 8'h57); push(0, 8'h10);
      n = 0;
      while (rd_n[0] < 2 && n < 20) begin
         @(negedge clk);
         n++;
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if ({rx_read[0], tx_start[0], bus_we[0], bus_re[0], busy[0], err[0]} !== 6'b0
          || {tx_data[0], bus_addr[0], bus_wdata[0]} !== 24'h0) begin
         failures++;
         $display("FAIL reset_mid_outputs: got %b %h, required 000000 000000",
                  {rx_read[0], tx_start[0], bus_we[0], bus_re[0], busy[0], err[0]},
                  {tx_data[0], bus_addr[0], bus_wdata[0]});
      end
      repeat (20) @(negedge clk);
      checks++;
      if (we_n[0] !== 0 || ts_n[0] !== 0 || rd_n[0] !== 2 || q0.size() !== 0) begin
         failures++;
         $display("FAIL reset_mid_quiet: got we=%0d ts=%0d pops=%0d left=%0d, required 0 0 2 0",
                  we_n[0], ts_n[0], rd_n[0], q0.size());
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] stream [8];
      stream = '{8'h57, 8'h30, 8'h11, 8'h52, 8'h30, 8'h57, 8'h31, 8'h22};
      clear_mon();
      for (int i = 0; i < 8; i++) push(0, stream[i]);
      wait_done(0, 200);
      checks++;
      if (txl0.size() !== 3) begin
         failures++;
         $display("FAIL b2b_count: got %0d responses, required 3", txl0.size());
      end else begin
         checks++;
         if (txl0[0] !== 8'h06 || txl0[1] !== 8'h3C || txl0[2] !== 8'h06) begin
            failures++;
            $display("FAIL b2b_order: got %h %h %h, required 06 3c 06", txl0[0], txl0[1], txl0[2]);
         end
      end
      checks++;
      if (we_n[0] !== 2 || re_n[0] !== 1 || we_addr[0] !== 8'h31 || we_data[0] !== 8'h22
          || rr_viol[0] !== 0 || rd_n[0] !== 8) begin
         failures++;
         $display("FAIL b2b_bus: got we=%0d re=%0d a=%h d=%h rr=%0d pops=%0d, required 2 1 31 22 0 8",
                  we_n[0], re_n[0], we_addr[0], we_data[0], rr_viol[0], rd_n[0]);
      end
   endtask

   initial begin
      rst = 1'b1;
      tx_fifo_full[0] = 1'b0;
      tx_fifo_full[1] = 1'b0;
      bus_rdata[0] = 8'hEE;
      bus_rdata[1] = 8'hEE;
      hist[0] = 4'h0;
      hist[1] = 4'h0;
      prev_rd[0] = 1'b0;
      prev_rd[1] = 1'b0;
      refresh();
      test_reset();
      test_write();
      test_read(0);
      test_read(1);
      test_nak();
      test_timeout();
      test_tx_full();
      test_reset_mid();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
